calc_sequencer: RTL

Multi-cycle, parametrised instruction sequencer for the calculator datapath. It fetches RV32I-style register and immediate ALU instructions from an external combinational program ROM and executes them on an internal register file. Write-back goes through a small combinational ALU. A start/busy/done handshake frames each run; illegal encodings are trapped; a registered debug port reads any register.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/calc_alu.sv | 27 ++
 rtl/calc_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and encodings for the calculator sequencer and its ALU.
package calc_pkg;

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StWb, StDone, StErr} state_e;

  typedef enum logic [2:0] {AluAdd, AluSub, AluSlt, AluSltu, AluXor, AluOr, AluAnd} alu_op_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // funct3 001 and 101 are shifts, which this datapath does not implement.
  function automatic logic f3_legal(logic [2:0] funct3);
    return (funct3 != 3'b001) && (funct3 != 3'b101);
  endfunction

  function automatic alu_op_e f3_to_alu_op(logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      F3_SLT:  op = AluSlt;
      F3_SLTU: op = AluSltu;
      F3_XOR:  op = AluXor;
      F3_OR:   op = AluOr;
      F3_AND:  op = AluAnd;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: modulo-2^W add/sub, signed/unsigned compare, bitwise logic.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  alu_op_e        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   y
);

  always_comb begin
    y = '0;
    unique case (op)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluSlt:  y = W'($signed(a) < $signed(b));
      AluSltu: y = W'(a < b);
      AluXor:  y = a ^ b;
      AluOr:   y = a | b;
      AluAnd:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle fetch/exec/write-back sequencer over an external program ROM,
// with an internal register file and a registered debug read port.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NREG  = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic [RW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] LastPc = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   instr_q;
  logic [W-1:0]  result_q;
  logic [W-1:0]  regs_q [NREG];
  logic [W-1:0]  dbg_data_q;
  logic          busy_q, done_q, illegal_q;

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rd, rs1, rs2;
  logic [W-1:0]  imm, alu_b, alu_y;
  logic          legal, use_imm;
  alu_op_e       alu_op;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[7 +: RW];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[15 +: RW];
  assign rs2    = instr_q[20 +: RW];
  assign funct7 = instr_q[31:25];
  assign imm    = W'($signed(instr_q[31:20]));

  always_comb begin
    alu_op  = f3_to_alu_op(funct3);
    use_imm = (opcode == OP_I);
    legal   = 1'b0;
    if (opcode == OP_I) begin
      legal = f3_legal(funct3);
    end else if (opcode == OP_R) begin
      if ((funct3 == F3_ADD) && (funct7 == F7_SUB)) begin
        legal  = 1'b1;
        alu_op = AluSub;
      end else begin
        legal = f3_legal(funct3) && (funct7 == F7_ZERO);
      end
    end
  end

  assign alu_b = use_imm ? imm : regs_q[rs2];

  calc_alu #(.W(W)) u_alu (
    .op (alu_op),
    .a  (regs_q[rs1]),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      instr_q   <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StFetch;
            pc_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StFetch: begin
          instr_q <= rom_data;
          state_q <= StExec;
        end
        StExec: begin
          if (instr_q == 32'h0) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!legal) begin
            state_q   <= StErr;
            busy_q    <= 1'b0;
            illegal_q <= 1'b1;
          end else begin
            result_q <= alu_y;
            state_q  <= StWb;
          end
        end
        StWb: begin
          // x0 is never written, so it keeps its reset value of zero.
          if (rd != '0) regs_q[rd] <= result_q;
          if (pc_q == LastPc) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q    <= pc_q + 1'b1;
            state_q <= StFetch;
          end
        end
        StErr: state_q <= StErr;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) dbg_data_q <= '0;
    else       dbg_data_q <= regs_q[dbg_addr];
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign dbg_data = dbg_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule
